// File: rtl/ads1220_ctrl.sv
// rtl/ads1220_ctrl.sv - ADS1220 sequencer: power-up, register configuration and DRDY-driven conversion reads
//
// Purpose:
//   Drives the 24-bit SPI frame engine through RESET, WREG (regs 0..1 and 2..3)
//   and START/SYNC after power-up. It then reads one conversion per DRDY falling
//   edge. A cfg_wr pulse schedules a reconfiguration at the next idle point.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   en                    enable continuous conversion reads
//   cfg_data, cfg_wr      new register 0..3 image and its one-cycle write strobe
//   drdy_n                ADC data-ready, asynchronous to clk
//   spi_go, spi_wrdat     frame request and payload to the frame engine
//   spi_ok, spi_rddat     frame done and received data from the frame engine
//   cs_n                  ADC chip select
//   sample, sample_vld    last conversion result and its one-cycle strobe
//   cfg_done              configuration complete
//   busy                  frame or wait in progress (low only in IDLE)
//   timeout               sticky DRDY watchdog flag
//
// Optional feature macro: ADS1220_DRDY_TIMEOUT_EN enables the DRDY watchdog.
// Without it timeout is tied low and the block waits for DRDY indefinitely.

`timescale 1ns/1ps

module ads1220_ctrl #(
  parameter logic [31:0] CFG_INIT   = 32'h0004_1000,
  parameter logic [15:0] PWRUP_WAIT = 16'd2000,
  parameter logic [15:0] RESET_WAIT = 16'd1000,
  parameter int          CS_GAP     = 4,
  parameter logic [23:0] TO_CYCLES  = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] cfg_data,
  input  logic        cfg_wr,
  input  logic        drdy_n,
  output logic        spi_go,
  output logic [23:0] spi_wrdat,
  input  logic        spi_ok,
  input  logic [23:0] spi_rddat,
  output logic        cs_n,
  output logic [23:0] sample,
  output logic        sample_vld,
  output logic        cfg_done,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_PWRUP, S_XRST, S_RWAIT, S_CFGA, S_CFGB, S_XSTART, S_IDLE, S_READ
  } state_t;

  // Sub-phase shared by all frame states.
  typedef enum logic [1:0] {
    PH_SETUP, PH_GO, PH_GAP
  } phase_t;

  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        go_q, go_d;
  logic [23:0] wrdat_q, wrdat_d;
  logic        cs_n_q, cs_n_d;
  logic [23:0] sample_q, sample_d;
  logic        sample_vld_q, sample_vld_d;
  logic        cfg_done_q, cfg_done_d;
  logic [31:0] shadow_q, shadow_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic        drdy_pend_q, drdy_pend_d;
  logic        drdy_s1_q, drdy_s1_d;
  logic        drdy_s2_q, drdy_s2_d;
  logic        drdy_s3_q, drdy_s3_d;

  logic        drdy_ev;
  logic        drdy_take;
  logic        start_en;
  state_t      start_st;

`ifdef ADS1220_DRDY_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
`else
  logic        unused_to_cycles;
  assign unused_to_cycles = ^TO_CYCLES;
`endif

  function automatic logic [23:0] frame_word(input state_t s, input logic [31:0] sh);
    case (s)
      S_XRST:   frame_word = 24'h06_0000;
      S_CFGA:   frame_word = {8'h41, sh[31:16]};
      S_CFGB:   frame_word = {8'h49, sh[15:0]};
      S_XSTART: frame_word = 24'h08_0000;
      default:  frame_word = 24'h00_0000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_PWRUP;
      phase_q      <= PH_SETUP;
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      go_q         <= 1'b0;
      wrdat_q      <= '0;
      cs_n_q       <= 1'b1;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      cfg_done_q   <= 1'b0;
      shadow_q     <= CFG_INIT;
      cfg_pend_q   <= 1'b0;
      drdy_pend_q  <= 1'b0;
      drdy_s1_q    <= 1'b1;
      drdy_s2_q    <= 1'b1;
      drdy_s3_q    <= 1'b1;
`ifdef ADS1220_DRDY_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      go_q         <= go_d;
      wrdat_q      <= wrdat_d;
      cs_n_q       <= cs_n_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      cfg_done_q   <= cfg_done_d;
      shadow_q     <= shadow_d;
      cfg_pend_q   <= cfg_pend_d;
      drdy_pend_q  <= drdy_pend_d;
      drdy_s1_q    <= drdy_s1_d;
      drdy_s2_q    <= drdy_s2_d;
      drdy_s3_q    <= drdy_s3_d;
`ifdef ADS1220_DRDY_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // s1/s2 synchronize; s3 is the previous synchronized level for edge detect.
  // The live edge is folded into drdy_ev so IDLE can react in the same cycle.
  assign drdy_ev = drdy_pend_q | (drdy_s3_q & ~drdy_s2_q);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    wait_cnt_d   = wait_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    go_d         = go_q;
    wrdat_d      = wrdat_q;
    cs_n_d       = cs_n_q;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    cfg_done_d   = cfg_done_q;
    shadow_d     = shadow_q;
    cfg_pend_d   = cfg_pend_q;
    drdy_s1_d    = drdy_n;
    drdy_s2_d    = drdy_s1_q;
    drdy_s3_d    = drdy_s2_q;
    drdy_take    = 1'b0;
    start_en     = 1'b0;
    start_st     = S_IDLE;
`ifdef ADS1220_DRDY_TIMEOUT_EN
    to_cnt_d     = '0;
    timeout_d    = timeout_q;
`endif

    case (state_q)
      S_PWRUP: begin
        if (wait_cnt_q == PWRUP_WAIT - 16'd1) begin
          start_en = 1'b1;
          start_st = S_XRST;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_RWAIT: begin
        if (wait_cnt_q == RESET_WAIT - 16'd1) begin
          start_en = 1'b1;
          start_st = S_CFGA;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        // Pending reconfiguration wins over a pending DRDY event.
        if (cfg_pend_q) begin
          start_en = 1'b1;
          start_st = S_CFGA;
        end else if (en && drdy_ev) begin
          start_en  = 1'b1;
          start_st  = S_READ;
          drdy_take = 1'b1;
        end
`ifdef ADS1220_DRDY_TIMEOUT_EN
        else if (en) begin
          if (to_cnt_q == TO_CYCLES - 24'd1) begin
            timeout_d = 1'b1;
            start_en  = 1'b1;
            start_st  = S_XRST;
          end else begin
            to_cnt_d = to_cnt_q + 24'd1;
          end
        end
`endif
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            // cs_n and wrdat were set on entry; never raise go over a stale ok.
            if (!spi_ok) begin
              go_d    = 1'b1;
              phase_d = PH_GO;
            end
          end
          PH_GO: begin
            if (spi_ok) begin
              go_d      = 1'b0;
              cs_n_d    = 1'b1;
              phase_d   = PH_GAP;
              gap_cnt_d = '0;
              if (state_q == S_READ) begin
                sample_d     = spi_rddat;
                sample_vld_d = 1'b1;
              end
            end
          end
          default: begin
            // Gap cycles only count once the engine has released spi_ok.
            if (!spi_ok) begin
              if (gap_cnt_q != GAP_LAST) begin
                gap_cnt_d = gap_cnt_q + 8'd1;
              end else begin
                case (state_q)
                  S_XRST: begin
                    state_d    = S_RWAIT;
                    wait_cnt_d = '0;
                  end
                  S_CFGA: begin
                    start_en = 1'b1;
                    start_st = cfg_pend_q ? S_CFGA : S_CFGB;
                  end
                  S_CFGB: begin
                    start_en = 1'b1;
                    if (cfg_pend_q) begin
                      start_st = S_CFGA;
                    end else begin
                      start_st   = S_XSTART;
                      cfg_done_d = 1'b1;
                    end
                  end
                  S_XSTART: begin
                    if (cfg_pend_q) begin
                      start_en = 1'b1;
                      start_st = S_CFGA;
                    end else begin
                      state_d = S_IDLE;
                    end
                  end
                  default: state_d = S_IDLE;
                endcase
              end
            end
          end
        endcase
      end
    endcase

    // Frame entry: chip select drops and payload settles one cycle before go.
    if (start_en) begin
      state_d = start_st;
      phase_d = PH_SETUP;
      cs_n_d  = 1'b0;
      wrdat_d = frame_word(start_st, shadow_q);
      if (start_st == S_CFGA) begin
        cfg_pend_d = 1'b0;
        cfg_done_d = 1'b0;
      end
    end

    // A write arriving as CFGA starts re-arms the pending flag with newer data.
    if (cfg_wr) begin
      shadow_d   = cfg_data;
      cfg_pend_d = 1'b1;
    end

    drdy_pend_d = en & drdy_ev & ~drdy_take;
  end

  assign spi_go     = go_q;
  assign spi_wrdat  = wrdat_q;
  assign cs_n       = cs_n_q;
  assign sample     = sample_q;
  assign sample_vld = sample_vld_q;
  assign cfg_done   = cfg_done_q;
  assign busy       = (state_q != S_IDLE);
`ifdef ADS1220_DRDY_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_ads1220_ctrl.sv
// tb/tb_ads1220_ctrl.sv - self-checking bench for ads1220_ctrl with frame-engine model and scoreboards

`timescale 1ns/1ps

module tb_ads1220_ctrl;

  localparam logic [15:0] PW      = 16'd20;
  localparam logic [15:0] RW      = 16'd10;
  localparam int          GAP     = 4;
  localparam logic [23:0] TO      = 24'd100;
  localparam int          ENG_LAT = 6;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] cfg_data;
  logic        cfg_wr;
  logic        drdy_n;
  logic        spi_go;
  logic [23:0] spi_wrdat;
  logic        spi_ok;
  logic [23:0] spi_rddat;
  logic        cs_n;
  logic [23:0] sample;
  logic        sample_vld;
  logic        cfg_done;
  logic        busy;
  logic        timeout;

  ads1220_ctrl #(
    .CFG_INIT   (32'h0004_1000),
    .PWRUP_WAIT (PW),
    .RESET_WAIT (RW),
    .CS_GAP     (GAP),
    .TO_CYCLES  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_data   (cfg_data),
    .cfg_wr     (cfg_wr),
    .drdy_n     (drdy_n),
    .spi_go     (spi_go),
    .spi_wrdat  (spi_wrdat),
    .spi_ok     (spi_ok),
    .spi_rddat  (spi_rddat),
    .cs_n       (cs_n),
    .sample     (sample),
    .sample_vld (sample_vld),
    .cfg_done   (cfg_done),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          frames = 0;
  int          nsamples = 0;
  int          viol = 0;
  int          hold_extra = 0;
  logic [23:0] rd_next = 24'h0;
  logic [23:0] exp_frame[$];
  logic [23:0] exp_sample[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (sampling #1 after each rising edge) for a chosen output to reach val.
  task automatic wait_for(input int sel, input logic val, input string tag);
    logic s;
    int   k;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      case (sel)
        0: s = spi_go;
        1: s = busy;
        2: s = cfg_done;
        3: s = sample_vld;
        default: s = timeout;
      endcase
      if (s === val) break;
    end
    if (k == 3000) check({tag, "_bound"}, 32'd0, 32'd1);
  endtask

  task automatic drdy_fall();
    @(posedge clk); #1;
    drdy_n = 1'b0;
  endtask

  task automatic push_init_frames();
    exp_frame.push_back(24'h06_0000);
    exp_frame.push_back(24'h41_0004);
    exp_frame.push_back(24'h49_1000);
    exp_frame.push_back(24'h08_0000);
  endtask

  // Frame engine model: checks each frame against the scoreboard at go rise.
  initial begin
    int est;
    int cnt;
    int hold;
    logic dropped;
    est = 0; cnt = 0; hold = 0; dropped = 1'b0;
    spi_ok = 1'b0;
    spi_rddat = 24'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        spi_ok = 1'b0;
        est = 0;
      end else begin
        case (est)
          0: if (spi_go) begin
               frames++;
               check("frame_cs_n", {31'd0, cs_n}, 32'd0);
               if (exp_frame.size() == 0) check("frame_unexpected", {8'd0, spi_wrdat}, 32'hFFFF_FFFF);
               else check("frame_word", {8'd0, spi_wrdat}, {8'd0, exp_frame.pop_front()});
               cnt = 0;
               est = 1;
             end
          1: begin
               cnt++;
               if (cnt == ENG_LAT) begin
                 spi_ok = 1'b1;
                 spi_rddat = rd_next;
                 hold = hold_extra;
                 dropped = 1'b0;
                 est = 2;
               end
             end
          default: begin
               if (spi_go && dropped) viol++;
               else if (!spi_go) begin
                 dropped = 1'b1;
                 if (hold == 0) begin
                   spi_ok = 1'b0;
                   est = 0;
                 end else hold--;
               end
             end
        endcase
      end
    end
  end

  // Sample scoreboard.
  initial begin
    logic prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && sample_vld) begin
        nsamples++;
        check("sample_vld_width", {31'd0, prev_vld}, 32'd0);
        if (exp_sample.size() == 0) check("sample_unexpected", {8'd0, sample}, 32'hFFFF_FFFF);
        else check("sample_value", {8'd0, sample}, {8'd0, exp_sample.pop_front()});
      end
      prev_vld = sample_vld;
    end
  end

  initial begin
    int k;
    int n;
    int base;
    int ns0;
    rst = 1'b1; en = 1'b0; cfg_data = 32'h0; cfg_wr = 1'b0; drdy_n = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_spi_go",     {31'd0, spi_go}, 32'd0);
    check("rst_spi_wrdat",  {8'd0, spi_wrdat}, 32'd0);
    check("rst_cs_n",       {31'd0, cs_n}, 32'd1);
    check("rst_sample",     {8'd0, sample}, 32'd0);
    check("rst_sample_vld", {31'd0, sample_vld}, 32'd0);
    check("rst_cfg_done",   {31'd0, cfg_done}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd1);
    check("rst_timeout",    {31'd0, timeout}, 32'd0);

    // Power-up sequence
    push_init_frames();
    base = frames;
    rst = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (!cs_n) break;
    end
    check("pwrup_cycles", k, 32'(PW));
    wait_for(2, 1'b1, "cfg_done_rise");
    check("frames_at_cfg_done", frames - base, 32'd3);
    wait_for(1, 1'b0, "idle_after_cfg");
    check("init_frames_left", exp_frame.size(), 32'd0);

    // Single conversion, DRDY-to-go latency
    en = 1'b1;
    repeat (3) @(posedge clk);
    rd_next = 24'h80_0001;
    exp_frame.push_back(24'h00_0000);
    exp_sample.push_back(24'h80_0001);
    drdy_fall();
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (spi_go) break;
    end
    check("drdy_to_go", k, 32'd4);
    drdy_n = 1'b1;
    wait_for(3, 1'b1, "vld_first");
    check("sample_800001", {8'd0, sample}, 32'h0080_0001);
    @(posedge clk); #1;
    check("vld_one_cycle", {31'd0, sample_vld}, 32'd0);
    wait_for(1, 1'b0, "idle_after_read");

    // Reconfiguration requested during a READ frame
    ns0 = nsamples;
    rd_next = 24'h12_3456;
    exp_frame.push_back(24'h00_0000);
    exp_sample.push_back(24'h12_3456);
    drdy_fall();
    wait_for(0, 1'b1, "read_go");
    drdy_n = 1'b1;
    exp_frame.push_back(24'h41_0A0B);
    exp_frame.push_back(24'h49_0C0D);
    exp_frame.push_back(24'h08_0000);
    cfg_data = 32'h0A0B_0C0D;
    cfg_wr = 1'b1;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    wait_for(2, 1'b0, "cfg_done_fall");
    check("sample_before_reconf", nsamples - ns0, 32'd1);
    wait_for(2, 1'b1, "cfg_done_rise2");
    wait_for(1, 1'b0, "idle_after_reconf");
    check("reconf_frames_left", exp_frame.size(), 32'd0);

    // spi_ok held high after go drops; second DRDY pending during the frame
    hold_extra = 5;
    rd_next = 24'hAB_CDEF;
    exp_frame.push_back(24'h00_0000);
    exp_frame.push_back(24'h00_0000);
    exp_sample.push_back(24'hAB_CDEF);
    exp_sample.push_back(24'hAB_CDEF);
    drdy_fall();
    wait_for(0, 1'b1, "hold_go1");
    drdy_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 drdy_n = 1'b0;
    wait_for(0, 1'b0, "hold_go_fall");
    n = 0;
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (spi_go) break;
      if (!spi_ok) n++;
    end
    check("okhold_gap_ge_csgap", {31'd0, (n >= GAP)}, 32'd1);
    check("okhold_no_go_over_ok", viol, 32'd0);
    drdy_n = 1'b1;
    hold_extra = 0;
    wait_for(1, 1'b0, "idle_after_hold");
    repeat (12) @(posedge clk);
    check("hold_frames_left", exp_frame.size(), 32'd0);

    // en low: DRDY discarded, no frames
    en = 1'b0;
    base = frames;
    drdy_fall();
    repeat (3) @(posedge clk);
    #1 drdy_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("en_low_no_frame", frames - base, 32'd0);
    check("en_low_cs_n", {31'd0, cs_n}, 32'd1);
    en = 1'b1;
    repeat (5) @(posedge clk);
    check("en_low_event_dropped", frames - base, 32'd0);

    // Reset in the middle of a READ frame
    exp_frame.push_back(24'h00_0000);
    drdy_fall();
    wait_for(0, 1'b1, "rst_mid_go");
    drdy_n = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_spi_go", {31'd0, spi_go}, 32'd0);
    check("rst_mid_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_mid_cfg_done", {31'd0, cfg_done}, 32'd0);
    repeat (2) @(negedge clk);
    push_init_frames();
    rst = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (!cs_n) break;
    end
    check("pwrup_cycles_after_rst", k, 32'(PW));
    wait_for(2, 1'b1, "cfg_done_after_rst");
    wait_for(1, 1'b0, "idle_after_rst");
    check("rst_frames_left", exp_frame.size(), 32'd0);

`ifdef ADS1220_DRDY_TIMEOUT_EN
    // Watchdog: no DRDY with en high
    push_init_frames();
    for (k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (timeout) break;
    end
    check("timeout_cycles", k, 32'(TO));
    en = 1'b0;
    wait_for(0, 1'b1, "timeout_xrst_go");
    wait_for(1, 1'b0, "idle_after_timeout");
    check("timeout_frames_left", exp_frame.size(), 32'd0);
    check("timeout_sticky", {31'd0, timeout}, 32'd1);
`else
    base = frames;
    repeat (150) @(posedge clk);
    #1;
    check("no_watchdog_timeout", {31'd0, timeout}, 32'd0);
    check("no_watchdog_frames", frames - base, 32'd0);
`endif

    check("samples_left", exp_sample.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ads1220_ctrl.md
# ads1220_ctrl

Sequencer for the ADS1220 24-bit SPI frame engine. It owns the engine's `go`/`wrdat`/`ok`/`rddat` handshake and drives the ADC chip select. After reset it issues RESET, writes the four configuration registers and issues START/SYNC. It then reads one 24-bit conversion per DRDY falling edge and presents each result as a one-cycle-valid sample to downstream logic.

## Interface
- `CFG_INIT`, default 32'h0004_1000: power-up value of config registers 0..3, reg0 in [31:24].
- `PWRUP_WAIT`, default 16'd2000: clk cycles to wait after `rst` release before the first frame.
- `RESET_WAIT`, default 16'd1000: clk cycles to wait after the RESET frame before configuring.
- `CS_GAP`, default 4: clk cycles with `cs_n` high and `spi_go` low between frames; minimum 2.
- `TO_CYCLES`, default 24'd1_000_000: DRDY watchdog limit, used only with the macro.
- `clk` in 1: system clock, also the frame engine clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: high to run continuous conversions.
- `cfg_data` in 32: new register 0..3 values.
- `cfg_wr` in 1: one-cycle pulse requesting reconfiguration with `cfg_data`.
- `drdy_n` in 1: ADC DRDY, asynchronous to `clk`.
- `spi_go` out 1: frame request to the engine.
- `spi_wrdat` out 24: frame payload, MSB first.
- `spi_ok` in 1: frame done from the engine; stays high until `spi_go` drops.
- `spi_rddat` in 24: received frame data, valid while `spi_ok` is high.
- `cs_n` out 1: ADC chip select.
- `sample` out 24: last conversion, two's complement.
- `sample_vld` out 1: one-cycle strobe marking a new `sample`.
- `cfg_done` out 1: high once a configuration has completed.
- `busy` out 1: high whenever a frame or wait is in progress.
- `timeout` out 1: sticky watchdog flag.

## Operation
- Reset values: `spi_go`=0, `spi_wrdat`=0, `cs_n`=1, `sample`=0, `sample_vld`=0, `cfg_done`=0, `busy`=1, `timeout`=0. The config shadow register loads `CFG_INIT`; the state goes to PWRUP.
- `drdy_n` passes through a 2-flop synchronizer. A DRDY event is a synchronized 1→0 edge. The event is held pending until it is consumed.
- States and frames:
  - PWRUP: counts `PWRUP_WAIT`, then goes to XRST.
  - XRST: frame 24'h06_0000, then goes to RWAIT.
  - RWAIT: counts `RESET_WAIT`, then goes to CFGA.
  - CFGA: frame {8'h41, reg0, reg1}, then goes to CFGB.
  - CFGB: frame {8'h49, reg2, reg3}; sets `cfg_done`; then goes to XSTART.
  - XSTART: frame 24'h08_0000, then goes to IDLE.
  - IDLE: goes to READ when `en` is high and a DRDY event is pending; `busy`=0 here.
  - READ: frame 24'h00_0000 with DIN held low; loads `sample` from `spi_rddat` and pulses `sample_vld`; returns to IDLE.
- Frame protocol, shared by every frame state:
  - Drive `cs_n`=0 and hold `wrdat` stable, then assert `spi_go`.
  - Hold until `spi_ok`=1, capture `spi_rddat`, then deassert `spi_go`.
  - Spend `CS_GAP` cycles with `cs_n`=1.
  - Never assert `spi_go` again while `spi_ok` is still 1.
- Reconfiguration:
  - A `cfg_wr` pulse latches `cfg_data` into the shadow register and sets a pending flag.
  - A frame in flight always completes first. At the next IDLE, the pending flag takes priority over DRDY; the block clears `cfg_done` and runs CFGA → CFGB → XSTART.
  - A `cfg_wr` during configuration restarts at CFGA after the current frame, using the newest data.
- With `en` low the block parks in IDLE with `cs_n`=1 and discards DRDY events. Configuration frames still run.
- `rst` mid-frame forces all reset values immediately, including `spi_go`=0. The sequence then restarts from PWRUP.

## Timing
- `sample` and `sample_vld` update on the first `clk` rising edge with `spi_ok`=1 in READ. `spi_go` falls on the same edge.
- DRDY edge to `spi_go` rising is 4 clk cycles: 2 synchronizer cycles, event detect, then IDLE→READ.
- Frame period is engine time + 1 + `CS_GAP` cycles.
- `cs_n` falls 1 cycle before `spi_go` rises and rises after `spi_ok` is seen.

## Configuration
- `ADS1220_DRDY_TIMEOUT_EN` defined: a counter runs while in IDLE with `en` high and no DRDY event.
  - Reaching `TO_CYCLES` sets `timeout`. The flag clears only on `rst`.
  - The block then reruns XRST → RWAIT → CFGA → CFGB → XSTART with the current shadow values.
- Macro undefined: no counter; `timeout` is tied to 0 and the block waits indefinitely.

## Test plan
- Release `rst`: after exactly `PWRUP_WAIT` cycles the frames are 060000, 41xxxx, 49xxxx, 080000 in that order; `cfg_done` rises after the 49 frame.
- `en`=1, DRDY falling, engine returns rddat 24'h80_0001: `sample`=800001 with a single-cycle `sample_vld`; 4 cycles from DRDY edge to `spi_go`.
- `cfg_wr` with 32'h0A0B0C0D during a READ frame: READ completes, then frames 410A0B, 490C0D, 080000; no sample is lost before the reconfiguration starts.
- `rst` pulse in the middle of a frame: `spi_go`=0 and `cs_n`=1 in the same cycle; the sequence resumes with the PWRUP count.
- `spi_ok` held high 5 extra cycles after `spi_go` drops: no new `spi_go` until `spi_ok`=0 plus `CS_GAP`.
- Macro defined, `TO_CYCLES`=100, no DRDY: `timeout`=1 at cycle 100 and a 060000 frame follows.
